// File: rtl/apb_master_req_if.sv
// Command, response and APB3 bus signals of the APB requester, with the
// requester-side (master) and environment-side (slave) views.
interface apb_master_req_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_req.sv
// APB3 requester: turns valid/ready commands into single APB transfers and
// reports read data and status on a one-cycle response strobe.
module apb_master_req #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 8
) (
  input  logic            pclk,
  input  logic            rst,
  apb_master_req_if.master bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);
  // Unused (all ones) when the timeout is disabled; TO_EN gates the compare.
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state_r;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 timeout_hit_s;

  // Command handshake and timeout detection
  always_comb begin
    bus.cmd_ready = (state_r == IDLE) && !rst;
    timeout_hit_s = TO_EN && (cnt_r == TO_LAST);
  end

  // Transfer sequencing, bus drive and response capture
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_r         <= IDLE;
      cnt_r           <= {CNT_WIDTH{1'b0}};
      bus.psel        <= 1'b0;
      bus.penable     <= 1'b0;
      bus.pwrite      <= 1'b0;
      bus.paddr       <= {ADDR_WIDTH{1'b0}};
      bus.pwdata      <= {DATA_WIDTH{1'b0}};
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= {DATA_WIDTH{1'b0}};
      bus.rsp_err     <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.paddr  <= bus.cmd_addr;
            bus.pwrite <= bus.cmd_write;
            bus.pwdata <= bus.cmd_write ? bus.cmd_wdata : {DATA_WIDTH{1'b0}};
            bus.psel   <= 1'b1;
            state_r    <= SETUP;
          end else begin
            state_r    <= IDLE;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          cnt_r       <= {CNT_WIDTH{1'b0}};
          state_r     <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a timeout in the same cycle
          if (bus.pready) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= bus.pslverr;
            bus.rsp_timeout <= 1'b0;
            bus.rsp_rdata   <= (!bus.pwrite && !bus.pslverr) ? bus.prdata
                                                            : {DATA_WIDTH{1'b0}};
            state_r         <= IDLE;
          end else if (timeout_hit_s) begin
            bus.psel        <= 1'b0;
            bus.penable     <= 1'b0;
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= 1'b1;
            bus.rsp_timeout <= 1'b1;
            bus.rsp_rdata   <= {DATA_WIDTH{1'b0}};
            state_r         <= IDLE;
          end else begin
            cnt_r   <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            state_r <= ACCESS;
          end
        end
        default: begin
          bus.psel    <= 1'b0;
          bus.penable <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master_req.md
Name: apb_master_req

Overview:
- APB requester (master) that turns a simple valid/ready command interface into single APB3 read/write transfers.
- Drives psel/penable/paddr/pwrite/pwdata toward APB completers such as the GPIO register block, and waits for pready.
- Returns read data and a status on a one-cycle response strobe.
- Includes a programmable wait-state timeout, so a dead completer cannot hang the bus.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and paddr
- DATA_WIDTH, 32, width of the wdata/rdata paths
- TIMEOUT_CYCLES, 16, maximum number of ACCESS cycles before abort; 0 disables the timeout
- CNT_WIDTH, 8, width of the wait counter; must satisfy TIMEOUT_CYCLES < 2**CNT_WIDTH

Ports:
- pclk  input  1  APB clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a pclk edge
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle completion strobe
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for errors
- rsp_err  output  1  pslverr seen or timeout
- rsp_timeout  output  1  transfer aborted by timeout
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready
- pslverr  input  1  APB error; tie 0 for completers without it

Behaviour:
- **Reset** (rst=1 at an edge):
  - state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; wait counter 0.
  - Reset mid-transfer: the bus is dropped on that edge and no response is issued.
- **Outputs:** all outputs are registered except cmd_ready, which is combinational: cmd_ready = (state==IDLE) && !rst.
- **IDLE:**
  - psel=0, penable=0.
  - rsp_valid is 1 only in the first IDLE cycle after a completion.
  - On accept: latch paddr=cmd_addr, pwrite=cmd_write, pwdata = cmd_write ? cmd_wdata : 0; psel=1; go to SETUP.
- **SETUP** (exactly one cycle, psel=1, penable=0): set penable=1, clear the wait counter, go to ACCESS.
- **ACCESS** (psel=1, penable=1):
  - **pready=1 at an edge:**
    - Drop psel and penable.
    - rsp_valid=1; rsp_err=pslverr; rsp_timeout=0.
    - rsp_rdata = (!pwrite && !pslverr) ? prdata : 0.
    - Go to IDLE.
  - **pready=0, TIMEOUT_CYCLES≠0, counter==TIMEOUT_CYCLES-1:**
    - Drop psel and penable; rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
    - Go to IDLE.
  - **Otherwise:** increment the counter and stay in ACCESS.
  - pready and timeout in the same cycle: pready wins, normal completion.
- **Bus signal stability:**
  - paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
  - They hold their last values while idle and change only on the next accept.
- **Response fields:** rsp_rdata, rsp_err and rsp_timeout hold until the next completion. rsp_valid is a single-cycle pulse with no backpressure.
- **Latency and throughput:**
  - Accept at edge n → SETUP cycle n+1 → ACCESS cycle n+2.
  - With zero wait states, rsp_valid is high in cycle n+3, the same cycle cmd_ready is high.
  - Back-to-back commands therefore give psel low for exactly one cycle between transfers.
  - Peak rate: one transfer per 3 cycles.
- **Command signals:** cmd_* are ignored outside an accept edge. The pready/pslverr/prdata inputs are ignored outside ACCESS.

Test Plan:
1. **Reset values:** assert rst for 2 cycles, then release with no command → all outputs 0, cmd_ready=1, psel never asserted.
2. **Write, zero wait:** write addr 0x0000_0000, data 0xDEAD_BEEF, completer pready=1 in first ACCESS → psel high 2 cycles, penable high 1 cycle, pwdata=0xDEAD_BEEF; rsp_valid one cycle with rsp_err=0, rsp_rdata=0; accepting GPIO register then reads back 0xDEAD_BEEF.
3. **Read, 3 wait states:** read addr 0x0, prdata=0x1234_5678, pready low for 3 ACCESS cycles then high → penable high 4 cycles, rsp_rdata=0x1234_5678, rsp_err=0; paddr/pwrite stable throughout.
4. **Timeout:** TIMEOUT_CYCLES=4, pready held 0 → penable high exactly 4 cycles, then psel/penable=0; rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
5. **pslverr, pready/timeout race, back-to-back:**
   - Read with pslverr=1 on the pready edge → rsp_err=1, rsp_timeout=0, rsp_rdata=0.
   - pready rising on the 4th ACCESS cycle with TIMEOUT_CYCLES=4 → normal completion.
   - Two back-to-back commands → psel low exactly 1 cycle between them.
6. **Reset mid-ACCESS:** assert rst during a waiting read → psel/penable 0 on the next edge, no rsp_valid; after release a new write completes normally.
